// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH multiplier controller.
//   It borrows the shared 33-bit ALU and runs shift-and-add, one multiplier
//   bit per ADD/SHIFT pair. It owns the ALU for the whole operation.
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous, active-high; clears all state
//   Start       in   request, sampled only in IDLE
//   OpA         in   multiplicand, latched on accept
//   OpB         in   multiplier, latched on accept
//   Busy        out  high from the cycle after accept through the last SHIFT
//   Done        out  one-cycle pulse, Product valid from this cycle
//   Product     out  result, held until the next Done
//   ALU_A       out  ALU operand A (bit 32 always 0)
//   ALU_B       out  ALU operand B (bit 32 always 0)
//   ALU_FunSel  out  ALU function select
//   ALU_WF      out  ALU flag write enable
//   ALUOut      in   ALU combinational result, low 2*WIDTH bits used
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for Start; ALU held at PASS with flags protected
// ADD   | Acc + Mcand through the ALU when the current multiplier bit is 1
// SHIFT | Mcand << 1 through the ALU; multiplier shifted right locally
// DONE  | Product valid, Done pulsed for one cycle

module alu_mul_sequencer #(
  parameter int         WIDTH       = 16,
  parameter logic [4:0] FUNSEL_ADD  = 5'b10100,
  parameter logic [4:0] FUNSEL_LSL  = 5'b11011,
  parameter logic [4:0] FUNSEL_PASS = 5'b10000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     OpA,
  input  logic [WIDTH-1:0]     OpB,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [32:0]          ALU_A,
  output logic [32:0]          ALU_B,
  output logic [4:0]           ALU_FunSel,
  output logic                 ALU_WF,
  input  logic [32:0]          ALUOut
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mul_r;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     alu_res;
  logic              last_iter;

  // The ALU carry (bit 32) is never needed: the product cannot overflow.
  logic unused_alu_carry;
  assign unused_alu_carry = ALUOut[32];

  assign alu_res   = ALUOut[PW-1:0];
  assign last_iter = (cnt == CNT_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mul_r   <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Start) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, OpA};
            mul_r <= OpB;
            cnt   <= '0;
          end
        end
        ADD: begin
          if (mul_r[0]) begin
            acc <= alu_res;
          end
        end
        SHIFT: begin
          mcand <= alu_res;
          mul_r <= mul_r >> 1;
          cnt   <= cnt + 1'b1;
          // Acc is final after the last ADD, so Product is loaded on the
          // edge that enters DONE and is already valid while Done is high.
          if (last_iter) begin
            Product <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_FunSel = FUNSEL_PASS;
    ALU_WF     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        Busy  = 1'b1;
        ALU_A = 33'(acc);
        ALU_B = 33'(mcand);
        if (mul_r[0]) begin
          ALU_FunSel = FUNSEL_ADD;
          ALU_WF     = 1'b1;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy       = 1'b1;
        ALU_A      = 33'(mcand);
        ALU_FunSel = FUNSEL_LSL;
        state_nxt  = last_iter ? DONE : ADD;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer with a behavioural ALU model.
module tb_alu_mul_sequencer;

  localparam logic [4:0] F_ADD  = 5'b10100;
  localparam logic [4:0] F_LSL  = 5'b11011;
  localparam logic [4:0] F_PASS = 5'b10000;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic        Busy;
  logic        Done;
  logic [31:0] Product;
  logic [32:0] ALU_A;
  logic [32:0] ALU_B;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [32:0] ALUOut;

  int          n_vec;
  int          n_err;
  logic [31:0] prev_p;

  alu_mul_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .OpA        (OpA),
    .OpB        (OpB),
    .Busy       (Busy),
    .Done       (Done),
    .Product    (Product),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FunSel (ALU_FunSel),
    .ALU_WF     (ALU_WF),
    .ALUOut     (ALUOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Shared ALU model.
  always_comb begin
    case (ALU_FunSel)
      F_ADD:   ALUOut = ALU_A + ALU_B;
      F_LSL:   ALUOut = {1'b0, ALU_A[30:0], 1'b0};
      default: ALUOut = ALU_A;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_wf, input bit chg);
    int         busy_bad;
    int         done_bad;
    int         fs_bad;
    int         wf_cnt;
    logic [4:0] fs_exp;
    busy_bad = 0;
    done_bad = 0;
    fs_bad   = 0;
    wf_cnt   = 0;
    @(negedge Clock);
    OpA   = a;
    OpB   = b;
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge Clock);
      if (chg && k == 5) begin
        OpA = ~a;
        OpB = ~b;
      end
      if (Busy !== (k <= 32)) busy_bad++;
      if (Done !== (k == 33)) done_bad++;
      if (ALU_WF === 1'b1) wf_cnt++;
      if (k == 33)          fs_exp = F_PASS;
      else if (k % 2 == 0)  fs_exp = F_LSL;
      else                  fs_exp = b[(k-1)/2] ? F_ADD : F_PASS;
      if (ALU_FunSel !== fs_exp) fs_bad++;
      if (k == 1) begin
        check("add_op_a", 64'(ALU_A), 64'd0);
        check("add_op_b", 64'(ALU_B), {48'd0, a});
      end
      if (k == 2) begin
        check("lsl_op_a", 64'(ALU_A), {48'd0, a});
        check("lsl_op_b", 64'(ALU_B), 64'd0);
      end
      if (k == 20) check("product_hold", 64'(Product), 64'(prev_p));
      if (k == 33) check("product", 64'(Product), 64'(exp_p));
    end
    check("busy_window", 64'(busy_bad), 64'd0);
    check("done_window", 64'(done_bad), 64'd0);
    check("funsel_seq", 64'(fs_bad), 64'd0);
    check("wf_count", 64'(wf_cnt), 64'(exp_wf));
    prev_p = exp_p;
  endtask

  initial begin
    int          d1;
    int          d2;
    int          dn;
    logic [31:0] p1;
    n_vec  = 0;
    n_err  = 0;
    prev_p = '0;
    Reset  = 1'b1;
    Start  = 1'b0;
    OpA    = '0;
    OpB    = '0;

    repeat (3) @(negedge Clock);
    check("rst_busy",    64'(Busy), 64'd0);
    check("rst_done",    64'(Done), 64'd0);
    check("rst_product", 64'(Product), 64'd0);
    check("rst_alu_a",   64'(ALU_A), 64'd0);
    check("rst_alu_b",   64'(ALU_B), 64'd0);
    check("rst_funsel",  64'(ALU_FunSel), 64'(F_PASS));
    check("rst_wf",      64'(ALU_WF), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_busy", 64'(Busy), 64'd0);

    run_op(16'd3,      16'd5,      32'h0000_000F, 2,  1'b0);
    run_op(16'hFFFF,   16'hFFFF,   32'hFFFE_0001, 16, 1'b0);
    run_op(16'h1234,   16'h0000,   32'h0000_0000, 0,  1'b0);

    // Start held high: back-to-back operations 34 cycles apart.
    d1 = 0;
    d2 = 0;
    dn = 0;
    p1 = '0;
    @(negedge Clock);
    OpA   = 16'd2;
    OpB   = 16'd7;
    Start = 1'b1;
    @(posedge Clock);
    for (int k = 1; k <= 67; k++) begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        dn++;
        if (dn == 1) begin
          d1 = k;
          p1 = Product;
        end else if (dn == 2) begin
          d2 = k;
        end
      end
    end
    Start = 1'b0;
    check("hold_done1_cycle", 64'(d1), 64'd33);
    check("hold_done2_cycle", 64'(d2), 64'd67);
    check("hold_done_count",  64'(dn), 64'd2);
    check("hold_product",     64'(p1), 64'h0E);
    prev_p = 32'h0000_000E;

    run_op(16'h00AB, 16'h0003, 32'h0000_0201, 2, 1'b1);

    // Reset in the middle of an operation.
    @(negedge Clock);
    OpA   = 16'h00FF;
    OpB   = 16'h0101;
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (10) @(negedge Clock);
    check("pre_rst_busy", 64'(Busy), 64'd1);
    Reset = 1'b1;
    #1;
    check("midrst_busy",    64'(Busy), 64'd0);
    check("midrst_wf",      64'(ALU_WF), 64'd0);
    check("midrst_funsel",  64'(ALU_FunSel), 64'(F_PASS));
    check("midrst_product", 64'(Product), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Done === 1'b1) dn++;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    check("midrst_product_after", 64'(Product), 64'd0);
    prev_p = '0;
    run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
